// File: rtl/priority_fifo_reader_if.sv
// ============================================================================
// Module      : priority_fifo_reader_if
// Description : FIFO read port and downstream valid/ready stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface priority_fifo_reader_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_read_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] rd_count;
    logic             busy;

    modport master (
        input  fifo_empty, fifo_data_out, out_ready,
        output fifo_read_en, out_valid, out_data, rd_count, busy
    );

    modport slave (
        output fifo_empty, fifo_data_out, out_ready,
        input  fifo_read_en, out_valid, out_data, rd_count, busy
    );
endinterface

`default_nettype wire

// File: rtl/priority_fifo_reader.sv
// ============================================================================
// Module      : priority_fifo_reader
// Description : Pops the priority FIFO and re-presents words as a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_fifo_reader #(
    parameter int WIDTH  = 8,
    parameter int RD_GAP = 1,
    parameter int CNT_W  = 16
) (
    input  wire                    clk,
    input  wire                    reset,
    priority_fifo_reader_if.master bus
);
    localparam int GAP_W = (RD_GAP < 2) ? 1 : $clog2(RD_GAP + 1);
    localparam logic [GAP_W-1:0] c_GAP_LOAD = GAP_W'(RD_GAP);
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    state_t           r_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_cap_pending;
    logic [WIDTH-1:0] r_buf [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_occ;
    logic [CNT_W-1:0] r_rd_count;

    logic w_space;
    logic w_issue;
    logic w_pop;

    // The in-flight word is counted as occupied so a capture can never overflow.
    assign w_space = (r_occ == 2'd0) || ((r_occ == 2'd1) && !r_cap_pending);
    assign w_issue = (r_state == S_IDLE) && !bus.fifo_empty && w_space && !reset;
    assign w_pop   = (r_occ != 2'd0) && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_gap_cnt     <= '0;
            r_cap_pending <= 1'b0;
            r_buf[0]      <= '0;
            r_buf[1]      <= '0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_occ         <= 2'd0;
            r_rd_count    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= c_GAP_LOAD;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - c_GAP_LAST;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Issue only happens in IDLE and capture always lands in GAP, so they never overlap.
            r_cap_pending <= w_issue;

            if (r_cap_pending) begin
                r_buf[r_wptr] <= bus.fifo_data_out;
                r_wptr        <= ~r_wptr;
            end

            if (w_pop) begin
                r_rptr <= ~r_rptr;
                if (r_rd_count != {CNT_W{1'b1}}) begin
                    r_rd_count <= r_rd_count + 1'b1;
                end
            end

            unique case ({r_cap_pending, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign bus.fifo_read_en = w_issue;
    assign bus.out_valid    = (r_occ != 2'd0);
    assign bus.out_data     = r_buf[r_rptr];
    assign bus.rd_count     = r_rd_count;
    assign bus.busy         = r_cap_pending || (r_state == S_GAP) || (r_occ != 2'd0);
endmodule

`default_nettype wire

// File: tb/tb_priority_fifo_reader.sv
// ============================================================================
// Module      : tb_priority_fifo_reader
// Description : Scoreboard bench with a behavioural two-class FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_fifo_reader;
    localparam int WIDTH  = 8;
    localparam int RD_GAP = 1;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    priority_fifo_reader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    priority_fifo_reader #(.WIDTH(WIDTH), .RD_GAP(RD_GAP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [WIDTH-1:0] q_hi [$];
    logic [WIDTH-1:0] q_lo [$];
    logic [WIDTH-1:0] sb   [$];
    int               rd_times [$];
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered data_out, empty flag reflects the pre-edge word count.
    initial begin : fifo_model
        int n;
        logic [WIDTH-1:0] w;
        bus.fifo_empty    <= 1'b1;
        bus.fifo_data_out <= '0;
        forever begin
            @(posedge clk);
            n = q_hi.size() + q_lo.size();
            if (bus.fifo_read_en && n > 0) begin
                if (q_hi.size() > 0) w = q_hi.pop_front();
                else                 w = q_lo.pop_front();
                bus.fifo_data_out <= w;
            end
            bus.fifo_empty <= (n == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.fifo_read_en) rd_times.push_back(cyc);
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none", bus.out_data);
            end else begin
                check("sb_data", {24'h0, bus.out_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || bus.busy || q_hi.size() != 0 || q_lo.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=pending expected=drained", name);
        end
    endtask

    task automatic wait_rd(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.fifo_read_en && k < 50);
        if (!bus.fifo_read_en) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_read expected=read_en", name);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        bus.out_ready = 1'b1;

        // Reset held while the FIFO reports data available.
        @(negedge clk);
        q_lo.push_back(8'h99);
        repeat (3) @(negedge clk);
        check("rst_read_en",  {31'h0, bus.fifo_read_en}, 32'h0);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_data", {24'h0, bus.out_data}, 32'h0);
        check("rst_rd_count", {16'h0, bus.rd_count}, 32'h0);
        check("rst_busy",     {31'h0, bus.busy}, 32'h0);
        sb.push_back(8'h99);
        reset = 1'b0;
        wait_drain("t1");
        check("t1_rd_count", {16'h0, bus.rd_count}, 32'h1);

        // Single word latency.
        do_reset();
        sb.push_back(8'hA5);
        q_lo.push_back(8'hA5);
        wait_rd("t2");
        @(negedge clk);
        check("t2_read_en_t1", {31'h0, bus.fifo_read_en}, 32'h0);
        check("t2_valid_t1",   {31'h0, bus.out_valid}, 32'h0);
        @(negedge clk);
        check("t2_valid_t2",   {31'h0, bus.out_valid}, 32'h1);
        check("t2_data_t2",    {24'h0, bus.out_data}, 32'hA5);
        @(negedge clk);
        check("t2_rd_count",   {16'h0, bus.rd_count}, 32'h1);
        check("t2_busy_t3",    {31'h0, bus.busy}, 32'h0);

        // Priority ordering and read spacing.
        rd_times.delete();
        q_lo.push_back(8'h10);
        q_hi.push_back(8'h20);
        q_hi.push_back(8'h21);
        sb.push_back(8'h20);
        sb.push_back(8'h21);
        sb.push_back(8'h10);
        wait_drain("t3");
        check("t3_reads", rd_times.size(), 32'd3);
        if (rd_times.size() == 3) begin
            check("t3_gap01", rd_times[1] - rd_times[0], RD_GAP + 1);
            check("t3_gap12", rd_times[2] - rd_times[1], RD_GAP + 1);
        end
        check("t3_rd_count", {16'h0, bus.rd_count}, 32'd4);

        // Stale empty flag must not trigger an extra read.
        rd_times.delete();
        q_hi.push_back(8'h55);
        sb.push_back(8'h55);
        wait_drain("t5");
        repeat (4) @(negedge clk);
        check("t5_reads", rd_times.size(), 32'd1);
        check("t5_rd_count", {16'h0, bus.rd_count}, 32'd5);

        // Backpressure: buffer fills at two words, head stays stable.
        bus.out_ready = 1'b0;
        rd_times.delete();
        for (int i = 0; i < 4; i++) begin
            q_hi.push_back(8'h41 + 8'(i));
            sb.push_back(8'h41 + 8'(i));
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) check("t4_hold_data", {24'h0, bus.out_data}, 32'h41);
        end
        check("t4_reads", rd_times.size(), 32'd2);
        check("t4_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t4_rd_count_held", {16'h0, bus.rd_count}, 32'd5);
        bus.out_ready = 1'b1;
        wait_drain("t4");
        check("t4_rd_count", {16'h0, bus.rd_count}, 32'd9);

        // Reset while a word is in flight.
        q_hi.push_back(8'h66);
        q_hi.push_back(8'h77);
        wait_rd("t6");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_valid",    {31'h0, bus.out_valid}, 32'h0);
        check("t6_read_en",  {31'h0, bus.fifo_read_en}, 32'h0);
        check("t6_rd_count", {16'h0, bus.rd_count}, 32'h0);
        check("t6_busy",     {31'h0, bus.busy}, 32'h0);
        repeat (2) @(negedge clk);
        check("t6_no_capture", {31'h0, bus.out_valid}, 32'h0);
        sb.push_back(8'h77);
        reset = 1'b0;
        wait_drain("t6");
        check("t6_rd_count_after", {16'h0, bus.rd_count}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
